// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package prog_loader_pkg;

    // Loader FSM states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CHK   = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_e;

    // A LEN byte of zero stands for a full 256-word image.
    localparam logic [8:0] LEN_ZERO_WORDS = 9'd256;

    // Byte-lane order: the first byte of a word lands in the top lane.
    localparam logic MSB_FIRST = 1'b1;

    // Translate the LEN byte into the number of words that follow.
    function automatic logic [8:0] len_to_words(input logic [7:0] len);
        logic [8:0] words_s;
        if (len == 8'd0) begin
            words_s = LEN_ZERO_WORDS;
        end else begin
            words_s = {1'b0, len};
        end
        return words_s;
    endfunction

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Packs a byte stream into memory words; first byte goes to the lane
// selected by MSB_FIRST. The word output already contains the byte being
// shifted in, so the caller can write it on the same edge that takes it.
module byte_packer
    import prog_loader_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [7:0]        byte_in,
    output logic [DATA_W-1:0] word,
    output logic              full
);

    logic [DATA_W-1:0] sreg_q;
    logic [DATA_W-1:0] sreg_d;
    logic [1:0]        lane_q;
    logic [1:0]        lane_d;
    logic [DATA_W-1:0] word_s;

    // Next shift-register and lane-count values.
    always_comb begin
        word_s = sreg_q;
        if (shift_en) begin
            if (MSB_FIRST) begin
                word_s = {sreg_q[DATA_W-9:0], byte_in};
            end else begin
                word_s = {byte_in, sreg_q[DATA_W-1:8]};
            end
        end else begin
            word_s = sreg_q;
        end

        if (clear) begin
            sreg_d = {DATA_W{1'b0}};
            lane_d = 2'd0;
        end else if (shift_en) begin
            sreg_d = word_s;
            lane_d = lane_q + 2'd1;
        end else begin
            sreg_d = sreg_q;
            lane_d = lane_q;
        end
    end

    // Shift register and lane counter state.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sreg_q <= {DATA_W{1'b0}};
            lane_q <= 2'd0;
        end else begin
            sreg_q <= sreg_d;
            lane_q <= lane_d;
        end
    end

    assign word = word_s;
    assign full = shift_en && (lane_q == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader for the 256x32 instruction memory; keeps the
// processor in reset until an image with a good checksum has been written.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_run
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [8:0]        cnt_q, cnt_d;
    logic [7:0]        xor_q, xor_d;
    logic              in_ready_q, in_ready_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              mem_wren_q, mem_wren_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              cpu_run_q, cpu_run_d;

    logic              accept_s;
    logic              pk_shift_s;
    logic              pk_clear_s;
    logic [DATA_W-1:0] pk_word_s;
    logic              pk_full_s;

    assign accept_s   = in_valid && in_ready_q;
    assign pk_shift_s = accept_s && (state_q == ST_DATA);
    assign pk_clear_s = start && (state_q == ST_IDLE);

    byte_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (pk_clear_s),
        .shift_en (pk_shift_s),
        .byte_in  (in_data),
        .word     (pk_word_s),
        .full     (pk_full_s)
    );

    // Frame sequencing: next state plus next values of every output register.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        xor_d      = xor_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_wren_d = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        cpu_run_d  = cpu_run_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_LEN;
                    busy_d    = 1'b1;
                    err_d     = 1'b0;
                    cpu_run_d = 1'b0;
                    addr_d    = {ADDR_W{1'b0}};
                    xor_d     = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LEN: begin
                if (accept_s) begin
                    cnt_d   = len_to_words(in_data);
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_LEN;
                end
            end
            ST_DATA: begin
                if (accept_s) begin
                    xor_d = xor_q ^ in_data;
                    if (pk_full_s) begin
                        state_d    = ST_WRITE;
                        mem_wren_d = 1'b1;
                        mem_addr_d = addr_q;
                        mem_data_d = pk_word_s;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_WRITE: begin
                // Address wraps to 0 after word 255; no write follows it.
                addr_d = addr_q + ADDR_W'(1);
                cnt_d  = cnt_q - 9'd1;
                if (cnt_q == 9'd1) begin
                    state_d = ST_CHK;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_CHK: begin
                if (accept_s) begin
                    busy_d = 1'b0;
                    if (in_data == xor_q) begin
                        state_d   = ST_DONE;
                        done_d    = 1'b1;
                        cpu_run_d = 1'b1;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end else begin
                    state_d = ST_CHK;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The stream is open exactly in the byte-accepting states.
        if ((state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CHK)) begin
            in_ready_d = 1'b1;
        end else begin
            in_ready_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= {ADDR_W{1'b0}};
            cnt_q      <= 9'd0;
            xor_q      <= 8'd0;
            in_ready_q <= 1'b0;
            mem_addr_q <= {ADDR_W{1'b0}};
            mem_data_q <= {DATA_W{1'b0}};
            mem_wren_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cpu_run_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            xor_q      <= xor_d;
            in_ready_q <= in_ready_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_wren_q <= mem_wren_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cpu_run_q  <= cpu_run_d;
        end
    end

    assign in_ready = in_ready_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign mem_wren = mem_wren_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign cpu_run  = cpu_run_q;

endmodule

// File: doc/prog_loader.md
# prog_loader

Instruction-memory loader that writes into the same 256×32 memory the processor fetches from. It accepts a framed byte stream (length, data, checksum) over a valid/ready byte interface and packs bytes into 32-bit words, MSB first. Each word is written to consecutive memory addresses starting at 0. It holds the processor in reset (`cpu_run` low) until a load completes with a good checksum, then releases it.

## Interface
Parameters:
- `ADDR_W`, 8, memory address width; the word count field covers 2^ADDR_W words.
- `DATA_W`, 32, memory word width; must be 4×8.

Ports:
- `clk` in 1: clock.
- `n_rst` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse that begins a load frame.
- `in_valid` in 1: byte on `in_data` is valid.
- `in_data` in 8: stream byte.
- `in_ready` out 1: loader accepts a byte this cycle.
- `mem_addr` out ADDR_W: memory write address.
- `mem_data` out DATA_W: memory write data.
- `mem_wren` out 1: memory write enable, one cycle per word.
- `busy` out 1: a frame is in progress.
- `done` out 1: one-cycle pulse when a load finishes with a good checksum.
- `err` out 1: sticky checksum-mismatch flag.
- `cpu_run` out 1: processor-enable; the processor is held in reset while this is low.

## Operation
- Frame format: LEN byte, then 4×N data bytes, then CHK byte.
  - N = LEN, except LEN = 0 means N = 256.
  - Each word is sent MSB first: byte0 → [31:24] … byte3 → [7:0].
  - CHK must equal the XOR of all data bytes. LEN is not included in the XOR.
- A byte is accepted when `in_valid & in_ready` is high at the rising edge.
- States:
  - IDLE: `in_ready` = 0. `start` → LEN, and `busy` rises, `err` clears, `cpu_run` falls, the address and XOR accumulator clear.
  - LEN: `in_ready` = 1. On accept, latch N into a 9-bit word counter → DATA.
  - DATA: `in_ready` = 1. Shift the byte into the packer and XOR it into the accumulator. On the 4th byte of a word → WRITE.
  - WRITE: `in_ready` = 0 and `mem_wren` = 1 for exactly one cycle, with `mem_addr` = current address and `mem_data` = the packed word. Next cycle the address increments and the counter decrements. If the counter reaches 0 → CHK, otherwise → DATA.
  - CHK: `in_ready` = 1. On accept:
    - match → DONE.
    - mismatch → ERR.
  - DONE: one cycle. `done` = 1, `cpu_run` ← 1, `busy` ← 0 → IDLE.
  - ERR: `err` ← 1, `busy` ← 0, `cpu_run` stays 0 → IDLE.
- `start` while `busy` is ignored. `start` in IDLE, including after DONE or ERR, reloads: `cpu_run` drops and `err` clears.
- Address: the last write of a 256-word frame goes to 255. The internal address then wraps to 0, but no further write occurs.
- `in_valid` low stalls in any accepting state indefinitely. There is no timeout.
- `mem_addr` and `mem_data` hold their last values outside WRITE.

## Timing
- Reset values: `in_ready` 0, `mem_addr` 0, `mem_data` 0, `mem_wren` 0, `busy` 0, `done` 0, `err` 0, `cpu_run` 0, state IDLE.
- `start` at edge t → LEN state and `in_ready` = 1 at t+1.
- Back-to-back bytes: one byte per cycle in LEN, DATA and CHK.
- The 4th byte of a word, accepted at edge t → `mem_wren` = 1 during cycle t+1. `in_ready` is low for that cycle, so there is one bubble per word.
- Minimum frame time is 1 + 5N + 1 + 1 cycles from the LEN accept to the `done` pulse.
- The CHK accept at edge t → `done` or `err` visible at t+1. `cpu_run` goes high at t+1 and stays high.
- `n_rst` asserted mid-frame → all outputs go to reset values immediately. A partial word is not written, and `cpu_run` = 0.

## Structure
- Shared package holds:
  - the state enum (IDLE, LEN, DATA, WRITE, CHK, DONE, ERR);
  - the LEN=0 → 256 constant;
  - the byte-lane order constant.
- One sub-module, `byte_packer`:
  - 32-bit shift register plus a 2-bit lane counter;
  - inputs: shift enable, byte, clear;
  - outputs: `word` and `full`, where `full` means the 4th byte was just taken.
- The FSM, address and word counter, XOR accumulator and output registers stay in `prog_loader`.

## Test plan
- Load, N=1: `start`; bytes 01, DE AD BE EF, CHK=22 → one write at addr 0 with data DEADBEEF; `done` pulse; `cpu_run`=1; `err`=0.
- Bad checksum, N=2: frame with CHK wrong → both words are written (addr 0, 1); `err`=1; no `done`; `cpu_run` stays 0. A following good `start` clears `err`.
- Full-depth frame, LEN=00: 256 words with data = address → 256 writes at addr 0..255, the last at 255; no write at 0 after that; `done`.
- Stalling source, N=2: random `in_valid` gaps and `start` pulses while `busy` → identical writes to the gap-free run; extra `start` pulses have no effect; `in_ready` = 0 exactly on the WRITE cycles.
- Reset mid-frame: `n_rst` low after the 2nd data byte → all outputs 0 immediately, no write. After release, a full N=1 load succeeds.
